// File: rtl/regfile_apb.sv
// Parametrised register file: combinational core read ports, one core write port,
// and an APB3 slave that yields to core writes through wait states and a stall timeout.
module regfile_apb #(
  parameter int                       DATA_W     = 8,
  parameter int                       ADDR_W     = 3,
  parameter int                       NUM_RD     = 2,
  parameter int                       APB_ADDR_W = 8,
  parameter logic [(2**ADDR_W)-1:0]   RO_MASK    = '0,
  parameter bit                       BYPASS     = 1'b1,
  parameter int                       MAX_STALL  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reg_write_en,
  input  logic [ADDR_W-1:0]          reg_write_addr,
  input  logic [DATA_W-1:0]          reg_write_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [APB_ADDR_W-1:0]      paddr,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int STALL_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic [DATA_W-1:0]     r_regs [DEPTH];
  logic [APB_ADDR_W-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_W-1:0]     r_pwdata;
  logic [STALL_W-1:0]    r_stall_cnt;
  logic [DATA_W-1:0]     r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [ADDR_W-1:0] w_idx;
  logic              w_setup, w_misalign, w_upper_nz, w_ro_hit, w_dec_err, w_timeout;
  logic              w_apb_commit, w_rd_ok, w_err_resp, w_stall;
  logic [DATA_W-1:0] w_rd_val;
  logic [DEPTH-1:0]  w_core_we, w_apb_we;

  assign w_idx      = r_paddr[ADDR_W+1:2];
  assign w_setup    = psel && !penable;
  assign w_misalign = |r_paddr[1:0];
  assign w_ro_hit   = r_pwrite && RO_MASK[w_idx];
  assign w_dec_err  = w_misalign || w_upper_nz || w_ro_hit;
  // The collision that would make MAX_STALL consecutive stalled cycles errors out instead.
  assign w_timeout  = (r_stall_cnt == STALL_W'(MAX_STALL - 1));

  generate
    if (APB_ADDR_W > ADDR_W + 2) begin : g_upper
      assign w_upper_nz = |r_paddr[APB_ADDR_W-1:ADDR_W+2];
    end else begin : g_no_upper
      assign w_upper_nz = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_state_next = S_ACCESS;
      S_ACCESS: begin
        if (!psel)
          w_state_next = S_IDLE;
        else if (w_dec_err || !r_pwrite || !reg_write_en || w_timeout)
          w_state_next = S_RESP;
      end
      S_RESP:   w_state_next = w_setup ? S_ACCESS : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_apb_commit = 1'b0;
    w_rd_ok      = 1'b0;
    w_err_resp   = 1'b0;
    w_stall      = 1'b0;
    if (r_state == S_ACCESS && psel) begin
      if (w_dec_err)          w_err_resp   = 1'b1;
      else if (!r_pwrite)     w_rd_ok      = 1'b1;
      else if (!reg_write_en) w_apb_commit = 1'b1;
      else if (w_timeout)     w_err_resp   = 1'b1;
      else                    w_stall      = 1'b1;
    end
  end

  assign w_rd_val = (BYPASS && reg_write_en && reg_write_addr == w_idx) ? reg_write_data
                                                                        : r_regs[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_stall_cnt <= '0;
    end else if (w_setup && r_state != S_ACCESS) begin
      r_paddr     <= paddr;
      r_pwrite    <= pwrite;
      r_pwdata    <= pwdata;
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= (w_state_next == S_RESP);
      r_pslverr <= w_err_resp;
      if (w_rd_ok) r_prdata <= w_rd_val;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_core_we[gi] = reg_write_en && (reg_write_addr == ADDR_W'(gi));
      assign w_apb_we[gi]  = w_apb_commit && (w_idx == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_core_we[i])     r_regs[i] <= reg_write_data;
        else if (w_apb_we[i]) r_regs[i] <= r_pwdata;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_data[gi*DATA_W +: DATA_W] =
          (BYPASS && reg_write_en && reg_write_addr == w_ra) ? reg_write_data :
          (BYPASS && w_apb_commit && w_idx == w_ra)          ? r_pwdata       :
                                                               r_regs[w_ra];
    end
  endgenerate

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;
endmodule

// File: tb/tb_regfile_apb.sv
// Bench for regfile_apb: directed scenarios plus random APB/core traffic against
// a transaction-level model of the register file.
module tb_regfile_apb;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int NUM_RD     = 2;
  localparam int APB_ADDR_W = 8;
  localparam int MAX_STALL  = 4;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam logic [DEPTH-1:0] RO_MASK = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_write_en = 1'b0;
  logic [ADDR_W-1:0] reg_write_addr = '0;
  logic [DATA_W-1:0] reg_write_data = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [APB_ADDR_W-1:0] paddr = '0;
  logic [DATA_W-1:0] pwdata = '0;
  logic [DATA_W-1:0] prdata;
  logic pready, pslverr;

  always #5 clk = ~clk;

  regfile_apb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .APB_ADDR_W(APB_ADDR_W),
    .RO_MASK(RO_MASK), .BYPASS(1'b1), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model_regs [DEPTH];
  logic [DATA_W-1:0] model_prdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < DEPTH; i += NUM_RD) begin
      for (int k = 0; k < NUM_RD; k++) rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(i + k);
      #1;
      for (int k = 0; k < NUM_RD; k++)
        check_val($sformatf("%s_reg%0d", tag, i + k), rd_data[k*DATA_W +: DATA_W], model_regs[i + k]);
    end
  endtask

  // One APB transfer; the core writes core_data to core_addr during the first core_n ACCESS cycles.
  task automatic apb_xfer(input bit wr, input logic [APB_ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input int core_n, input logic [ADDR_W-1:0] core_addr,
                          input logic [DATA_W-1:0] core_data, input string tag);
    int idx, exp_access, n_core, cyc;
    bit dec_err, exp_err, done;
    logic [DATA_W-1:0] exp_rd;
    idx     = int'(addr[ADDR_W+1:2]);
    dec_err = (addr[1:0] != 0) || (addr[APB_ADDR_W-1:ADDR_W+2] != 0) || (wr && RO_MASK[idx]);
    if (dec_err)                begin exp_access = 1;         exp_err = 1'b1; end
    else if (!wr)               begin exp_access = 1;         exp_err = 1'b0; end
    else if (core_n >= MAX_STALL) begin exp_access = MAX_STALL; exp_err = 1'b1; end
    else                        begin exp_access = core_n + 1; exp_err = 1'b0; end
    n_core = (core_n < exp_access) ? core_n : exp_access;
    exp_rd = (core_n >= 1 && int'(core_addr) == idx) ? core_data : model_regs[idx];

    rd_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(idx);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; reg_write_en = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      reg_write_en = (cyc < core_n); reg_write_addr = core_addr; reg_write_data = core_data;
      if (wr && !exp_err && cyc == exp_access - 1) begin
        #1 check_val({tag, "_commit_fwd"}, rd_data[1*DATA_W +: DATA_W], wdata);
      end
      @(posedge clk); #1;
      cyc++;
      if (pready) done = 1'b1;
      else check_val({tag, "_err_idle"}, pslverr, 1'b0);
    end
    reg_write_en = 1'b0; psel = 1'b0; penable = 1'b0;

    if (n_core > 0) model_regs[core_addr] = core_data;
    if (!exp_err && wr)  model_regs[idx] = wdata;
    if (!exp_err && !wr) model_prdata = exp_rd;

    check_val({tag, "_latency"}, cyc, exp_access);
    check_val({tag, "_pslverr"}, pslverr, exp_err);
    check_val({tag, "_prdata"}, prdata, model_prdata);
    @(posedge clk); #1;
    check_val({tag, "_pready_pulse"}, pready, 1'b0);
    check_all_regs(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr;
    int r, cn;
    logic [APB_ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    model_prdata = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("rst_pready", pready, 1'b0);
    check_val("rst_pslverr", pslverr, 1'b0);
    check_val("rst_prdata", prdata, 8'h00);
    check_all_regs("rst");

    apb_xfer(1'b1, 8'h1C, 8'hA5, 0, 3'd0, 8'h00, "wr_1c");
    apb_xfer(1'b0, 8'h1C, 8'h00, 0, 3'd0, 8'h00, "rd_1c");
    check_val("rd_1c_value", prdata, 8'hA5);

    apb_xfer(1'b1, 8'h0C, 8'h77, 2, 3'd3, 8'h3C, "stall2");
    apb_xfer(1'b1, 8'h0C, 8'h77, MAX_STALL - 1, 3'd3, 8'h3C, "stall_max_m1");
    apb_xfer(1'b1, 8'h0C, 8'h77, MAX_STALL, 3'd3, 8'h3C, "stall_timeout");
    check_val("stall_timeout_reg3", model_regs[3], 8'h3C);

    apb_xfer(1'b1, 8'h0D, 8'h11, 0, 3'd0, 8'h00, "misalign");
    apb_xfer(1'b1, 8'h40, 8'h22, 0, 3'd0, 8'h00, "upper_bits");
    apb_xfer(1'b1, 8'h00, 8'h33, 0, 3'd0, 8'h00, "ro_write");
    apb_xfer(1'b0, 8'h00, 8'h00, 0, 3'd0, 8'h00, "ro_read");

    // Same-cycle core write forwarded to read port 1.
    reg_write_en = 1'b1; reg_write_addr = 3'd5; reg_write_data = 8'h5A;
    rd_addr[1*ADDR_W +: ADDR_W] = 3'd5;
    #1 check_val("bypass_same_cycle", rd_data[1*DATA_W +: DATA_W], 8'h5A);
    @(posedge clk); #1;
    reg_write_en = 1'b0; model_regs[5] = 8'h5A;
    check_all_regs("bypass_after");

    // Back-to-back: read 0x04, then write 0x08 with setup in the RESP cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    check_val("b2b_pready1", pready, 1'b1);
    check_val("b2b_prdata", prdata, model_regs[1]);
    model_prdata = model_regs[1];
    penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'hC3;
    @(posedge clk); #1;
    check_val("b2b_gap", pready, 1'b0);
    penable = 1'b1;
    @(posedge clk); #1;
    check_val("b2b_pready2", pready, 1'b1);
    check_val("b2b_pslverr2", pslverr, 1'b0);
    model_regs[2] = 8'hC3;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check_val("b2b_end", pready, 1'b0);
    check_all_regs("b2b");

    // Protocol abort: psel dropped during ACCESS.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hEE;
    @(posedge clk); #1 psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check_val($sformatf("abort_pready%0d", i), pready, 1'b0);
    end
    check_all_regs("abort");

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 8)       a = APB_ADDR_W'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 8) a = APB_ADDR_W'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else             a = APB_ADDR_W'($urandom_range(32, 255));
      cn = wr ? $urandom_range(0, 5) : $urandom_range(0, 1);
      d  = DATA_W'($urandom);
      apb_xfer(wr, a, d, cn, ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom),
               $sformatf("rnd%0d", t));
    end

    // Reset during ACCESS of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 8'h99;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    model_prdata = '0;
    check_val("midrst_pready", pready, 1'b0);
    check_val("midrst_prdata", prdata, 8'h00);
    check_all_regs("midrst");
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_val("postrst_pready", pready, 1'b0);
    check_all_regs("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
